// File: rtl/comb_one_if.sv
// Switch-stage bus bundle for comb_one: five input flits, five output flits and
// the per-input drop flags.
//   nin/sin/ein/win/lin       : 10-bit flits into the switch ({valid, tag, dx, dy})
//   nout/sout/eout/wout/lout  : 10-bit registered flits out of the switch
//   drop                      : per-input loss flags, bit order {L,W,E,S,N}
// master = upstream/downstream side (drives the inputs, observes the outputs)
// slave  = the router switch stage
interface comb_one_if;
    localparam int unsigned FLIT_W = 10;
    localparam int unsigned NPORT  = 5;

    logic [FLIT_W-1:0] nin;
    logic [FLIT_W-1:0] sin;
    logic [FLIT_W-1:0] ein;
    logic [FLIT_W-1:0] win;
    logic [FLIT_W-1:0] lin;

    logic [FLIT_W-1:0] nout;
    logic [FLIT_W-1:0] sout;
    logic [FLIT_W-1:0] eout;
    logic [FLIT_W-1:0] wout;
    logic [FLIT_W-1:0] lout;

    logic [NPORT-1:0]  drop;

    modport master (
        output nin, sin, ein, win, lin,
        input  nout, sout, eout, wout, lout,
        input  drop
    );

    modport slave (
        input  nin, sin, ein, win, lin,
        output nout, sout, eout, wout, lout,
        output drop
    );
endinterface

// File: rtl/comb_one.sv
// comb_one: 5-port (N,S,E,W,Local) mesh-router switch stage.
// Each valid input flit is XY-routed (X first) to one output, every output
// arbitrates among its requesters independently, and the winners are registered
// onto the output ports. Losers are discarded and flagged on drop for one cycle.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, clears outputs, drop and arbiter state
//   bus    : comb_one_if.slave (nin..lin in, nout..lout out, drop out)
//
// Flit format: [9] valid, [8:6] port tag, [5:3] dest X, [2:0] dest Y.
// Output flit on grant: {1'b1, winning input port code, payload[5:0]}; else 10'b0.
//
// Configuration:
//   RR_ARB_EN undefined : fixed priority N>S>E>W>L, no arbiter state.
//   RR_ARB_EN defined   : round-robin per output with a 3-bit last-grant pointer
//                         (reset to L) so the search starts after the last winner.
module comb_one #(
    parameter logic [2:0] LOCAL_X = 3'd2,
    parameter logic [2:0] LOCAL_Y = 3'd2
) (
    input  logic      clk,
    input  logic      rst_n,
    comb_one_if.slave bus
);

    localparam int unsigned NPORT   = 5;
    localparam int unsigned FLIT_W  = 10;
    localparam int unsigned PORT_W  = 3;
    localparam int unsigned COORD_W = 3;
    localparam int unsigned PAY_W   = 2 * COORD_W;
    localparam int unsigned VLD_BIT = FLIT_W - 1;

    typedef enum logic [PORT_W-1:0] {
        P_N = 3'd0,
        P_S = 3'd1,
        P_E = 3'd2,
        P_W = 3'd3,
        P_L = 3'd4
    } port_e;

    // XY dimension-order routing: resolve X first, then Y, else deliver locally.
    function automatic port_e xy_route(input logic [COORD_W-1:0] dx,
                                       input logic [COORD_W-1:0] dy);
        port_e dir;
        if (dx > LOCAL_X) begin
            dir = P_E;
        end else if (dx < LOCAL_X) begin
            dir = P_W;
        end else if (dy > LOCAL_Y) begin
            dir = P_N;
        end else if (dy < LOCAL_Y) begin
            dir = P_S;
        end else begin
            dir = P_L;
        end
        return dir;
    endfunction

    // Input gather, index order N=0 .. L=4
    logic [NPORT-1:0][FLIT_W-1:0] in_flit;
    assign in_flit = {bus.lin, bus.win, bus.ein, bus.sin, bus.nin};

    // The incoming tag field carries no information for this stage.
    logic unused_in_tag;
    assign unused_in_tag = ^{bus.nin[8:6], bus.sin[8:6], bus.ein[8:6],
                             bus.win[8:6], bus.lin[8:6]};

    // Valid only on a clean 1; X/Z on the valid bit never raises a request.
    logic [NPORT-1:0] in_valid;
    always_comb begin
        in_valid = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            in_valid[i] = (in_flit[i][VLD_BIT] === 1'b1);
        end
    end

    // Route every input (result ignored unless the input is valid)
    port_e in_dir [NPORT];
    always_comb begin
        for (int unsigned i = 0; i < NPORT; i++) begin
            in_dir[i] = xy_route(in_flit[i][5:3], in_flit[i][2:0]);
        end
    end

    // Request matrix: req[o][i] means input i wants output o
    logic [NPORT-1:0][NPORT-1:0] req;
    always_comb begin
        req = '0;
        for (int unsigned o = 0; o < NPORT; o++) begin
            for (int unsigned i = 0; i < NPORT; i++) begin
                req[o][i] = in_valid[i] && (in_dir[i] == port_e'(PORT_W'(o)));
            end
        end
    end

`ifdef RR_ARB_EN
    // Last-granted input per output
    logic [NPORT-1:0][PORT_W-1:0] ptr_q;
`endif

    // Per-output arbitration.
    // Round-robin is done as two fixed-priority passes: first only inputs above
    // the pointer, then all inputs, which equals a search from pointer+1 mod 5.
    // With the pointer at L the first pass is empty, giving plain N>S>E>W>L.
    logic [NPORT-1:0]              gnt_vld;
    logic [NPORT-1:0][PORT_W-1:0]  gnt_src;
    logic [NPORT-1:0][PAY_W-1:0]   gnt_pay;
    always_comb begin
        gnt_vld = '0;
        gnt_src = '0;
        gnt_pay = '0;
        for (int unsigned o = 0; o < NPORT; o++) begin
`ifdef RR_ARB_EN
            for (int unsigned i = 0; i < NPORT; i++) begin
                if (!gnt_vld[o] && req[o][i] && (PORT_W'(i) > ptr_q[o])) begin
                    gnt_vld[o] = 1'b1;
                    gnt_src[o] = PORT_W'(i);
                    gnt_pay[o] = in_flit[i][PAY_W-1:0];
                end
            end
`endif
            for (int unsigned i = 0; i < NPORT; i++) begin
                if (!gnt_vld[o] && req[o][i]) begin
                    gnt_vld[o] = 1'b1;
                    gnt_src[o] = PORT_W'(i);
                    gnt_pay[o] = in_flit[i][PAY_W-1:0];
                end
            end
        end
    end

    // Which inputs won somewhere; a valid input that did not win is dropped.
    logic [NPORT-1:0] in_gnt;
    logic [NPORT-1:0] drop_d;
    always_comb begin
        in_gnt = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            for (int unsigned o = 0; o < NPORT; o++) begin
                if (gnt_vld[o] && (gnt_src[o] == PORT_W'(i))) begin
                    in_gnt[i] = 1'b1;
                end
            end
        end
        drop_d = in_valid & ~in_gnt;
    end

    // Output flit assembly: tag field replaced by the winning input's code
    logic [NPORT-1:0][FLIT_W-1:0] out_d;
    always_comb begin
        out_d = '0;
        for (int unsigned o = 0; o < NPORT; o++) begin
            if (gnt_vld[o]) begin
                out_d[o] = {1'b1, gnt_src[o], gnt_pay[o]};
            end
        end
    end

    // Output register stage
    logic [NPORT-1:0][FLIT_W-1:0] out_q;
    logic [NPORT-1:0]             drop_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            drop_q <= '0;
        end else begin
            out_q  <= out_d;
            drop_q <= drop_d;
        end
    end

`ifdef RR_ARB_EN
    // Pointer moves only on a grant; idle outputs keep their pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned o = 0; o < NPORT; o++) begin
                ptr_q[o] <= PORT_W'(P_L);
            end
        end else begin
            for (int unsigned o = 0; o < NPORT; o++) begin
                if (gnt_vld[o]) begin
                    ptr_q[o] <= gnt_src[o];
                end
            end
        end
    end
`endif

    assign bus.nout = out_q[P_N];
    assign bus.sout = out_q[P_S];
    assign bus.eout = out_q[P_E];
    assign bus.wout = out_q[P_W];
    assign bus.lout = out_q[P_L];
    assign bus.drop = drop_q;

endmodule

// File: tb/tb_comb_one.sv
// Directed bench for comb_one (LOCAL_X=2, LOCAL_Y=2).
// Drives inputs #1 after a rising edge and samples #1 after the next rising edge.
`timescale 1ns/1ps
module tb_comb_one;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    comb_one_if bus ();

    comb_one #(
        .LOCAL_X(3'd2),
        .LOCAL_Y(3'd2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [9:0] n, input logic [9:0] s, input logic [9:0] e,
                         input logic [9:0] w, input logic [9:0] l);
        bus.nin = n;
        bus.sin = s;
        bus.ein = e;
        bus.win = w;
        bus.lin = l;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [9:0] n, input logic [9:0] s,
                             input logic [9:0] e, input logic [9:0] w, input logic [9:0] l,
                             input logic [4:0] d);
        check($sformatf("%s.nout", tag), bus.nout, n);
        check($sformatf("%s.sout", tag), bus.sout, s);
        check($sformatf("%s.eout", tag), bus.eout, e);
        check($sformatf("%s.wout", tag), bus.wout, w);
        check($sformatf("%s.lout", tag), bus.lout, l);
        check($sformatf("%s.drop", tag), {5'b0, bus.drop}, {5'b0, d});
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    localparam logic [9:0] Z10 = 10'b0;
    localparam logic [9:0] F32 = 10'b1_000_011_010;   // dest (3,2) -> E

    logic [9:0] xflit;
    logic [9:0] zflit;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        drive(F32, F32, F32, F32, F32);

        // Reset held with all inputs valid
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", Z10, Z10, Z10, Z10, Z10, 5'b00000);

        // First capture after release: all five to E, N wins
        rst_n = 1'b1;
        step();
        check_all("all_to_e", Z10, Z10, F32, Z10, Z10, 5'b11110);

        // Mid-cycle asynchronous reset
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", Z10, Z10, Z10, Z10, Z10, 5'b00000);
        step();
        rst_n = 1'b1;

        // Single route N -> E
        drive(F32, Z10, Z10, Z10, Z10);
        step();
        check_all("single", Z10, Z10, F32, Z10, Z10, 5'b00000);

        // Output holds until the next edge even when inputs change
        drive(Z10, Z10, Z10, Z10, Z10);
        #3;
        check("hold.eout", bus.eout, F32);

        // Local delivery and S-route in the same cycle
        drive(Z10, 10'b1_000_010_001, Z10, Z10, 10'b1_000_010_010);
        step();
        check_all("local", Z10, 10'b1_001_010_001, Z10, Z10, 10'b1_100_010_010, 5'b00000);

        // Conflict at E: N, S, W -> N wins
        pulse_reset();
        drive(F32, F32, Z10, F32, Z10);
        step();
        check_all("conflict", Z10, Z10, F32, Z10, Z10, 5'b01010);

        // Parallel: five distinct outputs (E->W and W->E are fine too)
        drive(10'b1_000_010_011, 10'b1_000_010_001, 10'b1_000_001_010,
              10'b1_000_011_010, 10'b1_000_010_010);
        step();
        check_all("parallel", 10'b1_000_010_011, 10'b1_001_010_001, 10'b1_011_011_010,
                  10'b1_010_001_010, 10'b1_100_010_010, 5'b00000);

        // All five to W (dest (0,5)): one grant, four drops
        pulse_reset();
        drive(10'b1_000_000_101, 10'b1_000_000_101, 10'b1_000_000_101,
              10'b1_000_000_101, 10'b1_000_000_101);
        step();
        check_all("all_to_w", Z10, Z10, Z10, 10'b1_000_000_101, Z10, 5'b11110);

        // S > E > L priority at N output (dest (2,3))
        pulse_reset();
        drive(Z10, 10'b1_000_010_011, 10'b1_000_010_011, Z10, 10'b1_000_010_011);
        step();
        check_all("prio_sel", 10'b1_001_010_011, Z10, Z10, Z10, Z10, 5'b10100);

        // Coordinate boundaries; X resolves before Y; invalid local input
        drive(10'b1_000_111_111, 10'b1_000_010_111, 10'b1_000_010_000,
              10'b1_000_000_111, 10'b0_000_010_010);
        step();
        check_all("bounds", 10'b1_001_010_111, 10'b1_010_010_000, 10'b1_000_111_111,
                  10'b1_011_000_111, Z10, 5'b00000);

        // X/Z valid bit ignored; incoming tag bits overwritten
        xflit = 10'bx_000_011_010;
        zflit = 10'bz_000_010_010;
        drive(xflit, 10'b1_111_011_010, zflit, Z10, Z10);
        step();
        check_all("xz_tag", Z10, Z10, 10'b1_001_011_010, Z10, Z10, 5'b00000);

        // N and S fighting for E over three cycles
        pulse_reset();
        drive(F32, F32, Z10, Z10, Z10);
        step();
        check_all("fight0", Z10, Z10, F32, Z10, Z10, 5'b00010);
        step();
`ifdef RR_ARB_EN
        check_all("fight1", Z10, Z10, 10'b1_001_011_010, Z10, Z10, 5'b00001);
`else
        check_all("fight1", Z10, Z10, F32, Z10, Z10, 5'b00010);
`endif
        step();
        check_all("fight2", Z10, Z10, F32, Z10, Z10, 5'b00010);

        // Idle cycle, then the same fight: the pointer is held across the idle
        drive(Z10, Z10, Z10, Z10, Z10);
        step();
        check_all("idle", Z10, Z10, Z10, Z10, Z10, 5'b00000);
        drive(F32, F32, Z10, Z10, Z10);
        step();
`ifdef RR_ARB_EN
        check_all("after_idle", Z10, Z10, 10'b1_001_011_010, Z10, Z10, 5'b00001);
`else
        check_all("after_idle", Z10, Z10, F32, Z10, Z10, 5'b00010);
`endif

        drive(Z10, Z10, Z10, Z10, Z10);
        step();
        check_all("drain", Z10, Z10, Z10, Z10, Z10, 5'b00000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
